// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared between the VGA timing generator and the
// renderers that consume hc/vc/vidon and the delayed sync outputs.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       vidon;
  logic       hsync;
  logic       vsync;
  logic       vidon_d;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output pix_en, hc, vc, vidon, hsync, vsync, vidon_d,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    input  pix_en, hc, vc, vidon, hsync, vsync, vidon_d,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, hc/vc counters, visible
// window decode, pixel-delayed sync/video-enable and line/frame strobes.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int HPIXELS  = 800,
  parameter int VLINES   = 521,
  parameter int HSW      = 96,
  parameter int VSW      = 2,
  parameter int HBP      = 144,
  parameter int HFP      = 784,
  parameter int VBP      = 31,
  parameter int VFP      = 511,
  parameter int SYNC_DLY = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  vga_timing_gen_if.master vga
);

  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be 1..8");
  end
  if (SYNC_DLY < 1 || SYNC_DLY > 4) begin : g_bad_sync_dly
    $error("vga_timing_gen: SYNC_DLY must be 1..4");
  end
  if (HPIXELS < 1 || HPIXELS > 1024 || VLINES < 1 || VLINES > 1024) begin : g_bad_totals
    $error("vga_timing_gen: HPIXELS/VLINES must fit a 10-bit counter");
  end
  if (HSW < 0 || HSW > 1023 || HBP < 0 || HBP > 1023 || HFP < 0 || HFP > 1023 ||
      VSW < 0 || VSW > 1023 || VBP < 0 || VBP > 1023 || VFP < 0 || VFP > 1023) begin : g_bad_bounds
    $error("vga_timing_gen: timing bounds must fit 10 bits");
  end

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] H_SW   = 10'(HSW);
  localparam logic [9:0] V_SW   = 10'(VSW);
  localparam logic [9:0] H_BP   = 10'(HBP);
  localparam logic [9:0] H_FP   = 10'(HFP);
  localparam logic [9:0] V_BP   = 10'(VBP);
  localparam logic [9:0] V_FP   = 10'(VFP);

  logic [DW-1:0]       div_cnt;
  logic                pix_tick;
  logic [9:0]          hc_q;
  logic [9:0]          vc_q;
  logic [7:0]          frame_q;
  logic                vidon_c;
  logic                hs0;
  logic                vs0;
  logic [SYNC_DLY-1:0] hs_dly;
  logic [SYNC_DLY-1:0] vs_dly;
  logic [SYNC_DLY-1:0] vd_dly;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Gated by clr_n so the tick drops the moment reset is asserted.
  assign pix_tick = (div_cnt == DIV_LAST) && clr_n;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
    end else if (pix_tick) begin
      if (hc_q != H_LAST) begin
        hc_q <= hc_q + 10'd1;
      end else begin
        hc_q <= '0;
        if (vc_q != V_LAST) begin
          vc_q <= vc_q + 10'd1;
        end else begin
          vc_q    <= '0;
          frame_q <= frame_q + 8'd1;
        end
      end
    end
  end

  assign vidon_c = (hc_q >= H_BP) && (hc_q < H_FP) && (vc_q >= V_BP) && (vc_q < V_FP);
  assign hs0     = (hc_q >= H_SW);
  assign vs0     = (vc_q >= V_SW);

  // Stage 0 captures the decode of the pixel just ending, so the last stage
  // lags hc/vc by exactly SYNC_DLY pixel periods.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hs_dly <= '1;
      vs_dly <= '1;
      vd_dly <= '0;
    end else if (pix_tick) begin
      hs_dly[0] <= hs0;
      vs_dly[0] <= vs0;
      vd_dly[0] <= vidon_c;
      for (int i = 1; i < SYNC_DLY; i++) begin
        hs_dly[i] <= hs_dly[i-1];
        vs_dly[i] <= vs_dly[i-1];
        vd_dly[i] <= vd_dly[i-1];
      end
    end
  end

  assign vga.pix_en      = pix_tick;
  assign vga.hc          = hc_q;
  assign vga.vc          = vc_q;
  assign vga.vidon       = vidon_c;
  assign vga.hsync       = hs_dly[SYNC_DLY-1];
  assign vga.vsync       = vs_dly[SYNC_DLY-1];
  assign vga.vidon_d     = vd_dly[SYNC_DLY-1];
  assign vga.line_start  = pix_tick && (hc_q == 10'd0);
  assign vga.frame_start = pix_tick && (hc_q == 10'd0) && (vc_q == 10'd0);
  assign vga.frame_cnt   = frame_q;

endmodule
